// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage producing the IF/ID pipeline register
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FQ_DEPTH        = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic        if_id_valid_inst
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          FQ_AW = $clog2(FQ_DEPTH);
  localparam int          FQ_CW = $clog2(FQ_DEPTH + 1);
  localparam int          OS_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int          OS_CW = $clog2(MAX_OUTSTANDING + 1);

  // request-PC FIFO pointer advance; depth need not be a power of two
  function automatic logic [OS_AW-1:0] os_next(input logic [OS_AW-1:0] p);
    if (p == OS_AW'(MAX_OUTSTANDING - 1)) os_next = '0;
    else                                  os_next = p + OS_AW'(1);
  endfunction

  // architectural state
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [OS_CW-1:0] out_q, out_d;
  logic [OS_CW-1:0] drop_q, drop_d;
  logic [OS_AW-1:0] pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;
  logic [FQ_AW-1:0] fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
  logic [FQ_CW-1:0] fq_cnt_q, fq_cnt_d;
  logic [31:0]      ir_q, ir_d, pc_q, pc_d;
  logic             valid_q, valid_d;

  // storage arrays (written only when their slot becomes live)
  logic [31:0] pcf_mem [MAX_OUTSTANDING];
  logic [31:0] fq_pc   [FQ_DEPTH];
  logic [31:0] fq_ir   [FQ_DEPTH];

  logic [31:0] occupancy;
  logic        req_fire, resp_fire, resp_keep;
  logic        fq_push, fq_pop, bypass;
  logic [31:0] resp_pc;

  // Slots already committed (in flight + buffered) bound new requests so a
  // response can always be stored even while decode is stalled.
  assign occupancy      = 32'(out_q) + 32'(fq_cnt_q);
  assign imem_req_valid = !rst && !ex_take_branch &&
                          (32'(out_q) < 32'(MAX_OUTSTANDING)) &&
                          (occupancy < 32'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_fire      = imem_resp_valid && !rst;
  assign resp_pc        = pcf_mem[pcf_rd_q];
  assign resp_keep      = resp_fire && (drop_q == '0) && !ex_take_branch;
  assign fq_pop         = !ex_take_branch && !id_stall && (fq_cnt_q != '0);
  assign fq_push        = resp_keep && (id_stall || (fq_cnt_q != '0));
  assign bypass         = resp_keep && !id_stall && (fq_cnt_q == '0);

  assign if_id_IR         = ir_q;
  assign if_id_PC         = pc_q;
  assign if_id_valid_inst = valid_q;

  // next-state: request bookkeeping, drop accounting, queue and IF/ID priority
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    pcf_wr_d   = pcf_wr_q;
    pcf_rd_d   = pcf_rd_q;
    fq_wr_d    = fq_wr_q;
    fq_rd_d    = fq_rd_q;
    fq_cnt_d   = fq_cnt_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    valid_d    = valid_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      pcf_wr_d   = os_next(pcf_wr_q);
    end
    if (resp_fire) pcf_rd_d = os_next(pcf_rd_q);

    case ({req_fire, resp_fire})
      2'b10:   out_d = out_q + OS_CW'(1);
      2'b01:   out_d = out_q - OS_CW'(1);
      default: out_d = out_q;
    endcase

    if (ex_take_branch) begin
      // everything still in flight belongs to the old path, including this
      // cycle's response which is thrown away right now
      fetch_pc_d = ex_target_pc;
      drop_d     = out_q - OS_CW'(resp_fire);
      fq_wr_d    = '0;
      fq_rd_d    = '0;
      fq_cnt_d   = '0;
      ir_d       = NOP;
      valid_d    = 1'b0;
    end else begin
      if (resp_fire && (drop_q != '0)) drop_d = drop_q - OS_CW'(1);
      if (fq_push) fq_wr_d = fq_wr_q + FQ_AW'(1);
      if (fq_pop)  fq_rd_d = fq_rd_q + FQ_AW'(1);
      case ({fq_push, fq_pop})
        2'b10:   fq_cnt_d = fq_cnt_q + FQ_CW'(1);
        2'b01:   fq_cnt_d = fq_cnt_q - FQ_CW'(1);
        default: fq_cnt_d = fq_cnt_q;
      endcase
      if (!id_stall) begin
        if (fq_pop) begin
          ir_d    = fq_ir[fq_rd_q];
          pc_d    = fq_pc[fq_rd_q];
          valid_d = 1'b1;
        end else if (bypass) begin
          ir_d    = imem_resp_data;
          pc_d    = resp_pc;
          valid_d = 1'b1;
        end else begin
          ir_d    = NOP;
          valid_d = 1'b0;
        end
      end
    end
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      pcf_wr_q   <= '0;
      pcf_rd_q   <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
      fq_cnt_q   <= '0;
      ir_q       <= NOP;
      pc_q       <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      pcf_wr_q   <= pcf_wr_d;
      pcf_rd_q   <= pcf_rd_d;
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
      fq_cnt_q   <= fq_cnt_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  // record accepted addresses and buffer kept responses
  always_ff @(posedge clk) begin
    if (req_fire) pcf_mem[pcf_wr_q] <= fetch_pc_q;
    if (fq_push) begin
      fq_pc[fq_wr_q] <= resp_pc;
      fq_ir[fq_wr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage with a reference model
module tb_if_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam int          FQ       = 2;
  localparam int          MO       = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stall = 1'b0;
  logic        ex_take_branch = 1'b0;
  logic [31:0] ex_target_pc = 32'h0;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic        if_id_valid_inst;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC), .FQ_DEPTH(FQ), .MAX_OUTSTANDING(MO)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_stall         (id_stall),
    .ex_take_branch   (ex_take_branch),
    .ex_target_pc     (ex_target_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_valid_inst (if_id_valid_inst)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = 0;

  // model of the fetch stage: fetch PC, in-flight list, buffered instructions
  logic [31:0] m_pc, m_ir, m_ifpc;
  logic        m_v;
  int          m_drop;
  bit          m_init = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] q_pc[$];
  logic [31:0] q_ir[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_0033;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // one clock cycle: drive inputs, compare against the model, advance the model
  task automatic step(input logic stall, input logic br, input logic [31:0] tgt, input logic rdy);
    logic        rv, fire, resp, keep;
    logic [31:0] r_pc, r_ir;
    int          due;
    r_pc = 32'h0;
    r_ir = 32'h0;
    resp = !rst && (pend_due.size() > 0) && (pend_due[0] == cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(pend_addr[0]) : 32'hDEAD_BEEF;
    id_stall        = stall;
    ex_take_branch  = br;
    ex_target_pc    = tgt;
    imem_req_ready  = rdy;
    #1;
    rv = !rst && !br && (pend_addr.size() < MO) && ((pend_addr.size() + q_pc.size()) < FQ);
    if (m_init) begin
      chk("req_valid", 32'(imem_req_valid), 32'(rv));
      chk("req_addr", imem_req_addr, m_pc);
      chk("if_id_valid", 32'(if_id_valid_inst), 32'(m_v));
      chk("if_id_PC", if_id_PC, m_ifpc);
      chk("if_id_IR", if_id_IR, m_ir);
    end
    fire = rv && rdy;
    if (rst) begin
      m_pc = RST_PC; m_ir = NOP; m_ifpc = 32'h0; m_v = 1'b0; m_drop = 0;
      q_pc.delete(); q_ir.delete(); pend_addr.delete(); pend_due.delete();
      last_due = 0;
      m_init = 1;
    end else begin
      if (resp) begin
        r_pc = pend_addr.pop_front();
        void'(pend_due.pop_front());
        r_ir = mem_word(r_pc);
      end
      if (br) begin
        m_drop = pend_addr.size();
        q_pc.delete(); q_ir.delete();
        m_ir = NOP; m_v = 1'b0; m_pc = tgt;
      end else begin
        keep = resp && (m_drop == 0);
        if (resp && m_drop > 0) m_drop--;
        if (stall) begin
          if (keep) begin q_pc.push_back(r_pc); q_ir.push_back(r_ir); end
        end else if (q_pc.size() > 0) begin
          m_ifpc = q_pc.pop_front(); m_ir = q_ir.pop_front(); m_v = 1'b1;
          if (keep) begin q_pc.push_back(r_pc); q_ir.push_back(r_ir); end
        end else if (keep) begin
          m_ifpc = r_pc; m_ir = r_ir; m_v = 1'b1;
        end else begin
          m_ir = NOP; m_v = 1'b0;
        end
        if (fire) begin
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          pend_addr.push_back(m_pc);
          pend_due.push_back(due);
          last_due = due;
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("reset req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset IR", if_id_IR, NOP);
    chk("reset PC", if_id_PC, 32'h0);
    chk("reset valid", 32'(if_id_valid_inst), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);

    // streaming with zero-wait memory, then a 4-cycle decode stall at 0x8
    reset_seq();
    lat = 1;
    step(0, 0, 32'h0, 1); chk("s1 k1 valid", 32'(if_id_valid_inst), 32'd0);
    step(0, 0, 32'h0, 1); chk("s1 first valid", 32'(if_id_valid_inst), 32'd1);
    chk("s1 first PC", if_id_PC, 32'h0);
    chk("s1 first IR", if_id_IR, mem_word(32'h0));
    step(0, 0, 32'h0, 1); chk("s1 PC 4", if_id_PC, 32'h4);
    step(0, 0, 32'h0, 1); chk("s1 PC 8", if_id_PC, 32'h8);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 32'h0, 1);
      chk("s1 stall hold PC", if_id_PC, 32'h8);
    end
    chk("s1 stall req_valid low", 32'(imem_req_valid), 32'd0);
    step(0, 0, 32'h0, 1); chk("s1 after stall C", if_id_PC, 32'hC);
    step(0, 0, 32'h0, 1); chk("s1 after stall 10", if_id_PC, 32'h10);
    step(0, 0, 32'h0, 1); chk("s1 after stall 14", if_id_PC, 32'h14);
    repeat (4) step(0, 0, 32'h0, 1);

    // redirect with two slow responses in flight
    reset_seq();
    lat = 3;
    step(0, 1, 32'h10, 1);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    step(0, 1, 32'h100, 1);
    chk("s2 redirect IR", if_id_IR, NOP);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0, 1);
      chk("s2 drop valid low", 32'(if_id_valid_inst), 32'd0);
    end
    step(0, 0, 32'h0, 1); chk("s2 target PC", if_id_PC, 32'h100);
    chk("s2 target valid", 32'(if_id_valid_inst), 32'd1);
    step(0, 0, 32'h0, 1); chk("s2 target+4", if_id_PC, 32'h104);
    repeat (3) step(0, 0, 32'h0, 1);

    // redirect together with stall and an arriving response
    reset_seq();
    lat = 2;
    repeat (5) step(0, 0, 32'h0, 1);
    step(1, 1, 32'h200, 1);
    chk("s3 redirect valid", 32'(if_id_valid_inst), 32'd0);
    chk("s3 redirect IR", if_id_IR, NOP);
    step(0, 0, 32'h0, 1); chk("s3 wait valid 1", 32'(if_id_valid_inst), 32'd0);
    step(0, 0, 32'h0, 1); chk("s3 wait valid 2", 32'(if_id_valid_inst), 32'd0);
    step(0, 0, 32'h0, 1); chk("s3 target PC", if_id_PC, 32'h200);
    repeat (3) step(0, 0, 32'h0, 1);

    // memory not ready for 5 cycles
    reset_seq();
    lat = 1;
    repeat (3) step(0, 0, 32'h0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 32'h0, 0);
      chk("s4 held valid", 32'(imem_req_valid), 32'd1);
      chk("s4 held addr", imem_req_addr, 32'hC);
    end
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1); chk("s4 resumed PC", if_id_PC, 32'hC);
    repeat (2) step(0, 0, 32'h0, 1);

    // address wrap, then reset mid-stream
    reset_seq();
    lat = 1;
    step(0, 1, 32'hFFFF_FFF8, 1);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1); chk("s5 wrap addr", imem_req_addr, 32'h0);
    repeat (3) step(0, 0, 32'h0, 1);
    rst = 1'b1;
    step(0, 0, 32'h0, 1);
    chk("s5 rst req_valid", 32'(imem_req_valid), 32'd0);
    chk("s5 rst req_addr", imem_req_addr, RST_PC);
    chk("s5 rst IR", if_id_IR, NOP);
    chk("s5 rst PC", if_id_PC, 32'h0);
    chk("s5 rst valid", 32'(if_id_valid_inst), 32'd0);
    rst = 1'b0;
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1); chk("s5 restart PC", if_id_PC, RST_PC);
    chk("s5 restart valid", 32'(if_id_valid_inst), 32'd1);
    repeat (3) step(0, 0, 32'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
